// File: rtl/keypad_scan_sequencer.sv
// 4x4 keypad scanner: one-hot column drive, per-column settle, row sample,
// change detection against a key map, press/release events through a FIFO.
module keypad_scan_sequencer #(
  parameter int SETTLE_CYCLES = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [1:0]  col_idx,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_code,
  output logic        evt_press,
  output logic [15:0] key_state,
  output logic        overflow,
  input  logic        clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_N = CW'(FIFO_DEPTH);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_EVAL   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    samp_q, samp_d;
  logic [1:0]    row_q, row_d;
  logic [15:0]   ks_q, ks_d;
  logic          ovf_q, ovf_d;
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] fill_q, fill_d;

  logic [3:0] key_idx;
  logic       diff;
  logic       empty;
  logic       full;
  logic       pop;
  logic       push;

  // Key code {row, col} doubles as the key_state bit index.
  assign key_idx = {row_q, col_q};
  assign empty   = (fill_q == '0);
  assign full    = (fill_q == FULL_N);
  assign pop     = !empty && evt_ready;
  assign diff    = (state_q == S_EVAL) &&
                   (samp_q[row_q] != ks_q[key_idx]);
  assign push    = diff && (!full || pop);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    row_d   = row_q;
    ks_d    = ks_q;
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
    fill_d  = fill_q + CW'(push) - CW'(pop);
    // A dropped event sets the flag even if a clear arrives together.
    ovf_d   = (diff && !push) || (ovf_q && !clear_overflow);
    if (push) ks_d[key_idx] = samp_q[row_q];
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_DRIVE;
          col_d   = 2'd0;
          cnt_d   = 8'd0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      S_SAMPLE: begin
        samp_d  = rows;
        row_d   = 2'd0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) begin
          if (enable) begin
            state_d = S_DRIVE;
            col_d   = col_q + 2'd1;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_IDLE;
            col_d   = 2'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
      samp_q  <= '0;
      row_q   <= '0;
      ks_q    <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      fill_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      row_q   <= row_d;
      ks_q    <= ks_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      if (push) mem_q[wr_q] <= {key_idx, samp_q[row_q]};
    end
  end

  assign cols      = (state_q == S_IDLE) ? 4'b0000 : (4'b0001 << col_q);
  assign col_idx   = col_q;
  assign evt_valid = !empty;
  assign evt_code  = mem_q[rd_q][4:1];
  assign evt_press = mem_q[rd_q][0];
  assign key_state = ks_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// Randomized keypad bench: a matrix model drives rows from cols, and a
// slot-timed event model predicts cols, events, key map and overflow.
module tb_keypad_scan_sequencer;

  localparam int S = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [1:0]  col_idx;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic [15:0] key_state;
  logic        overflow;
  logic        clear_overflow;
  logic [15:0] pressed;

  keypad_scan_sequencer #(
    .SETTLE_CYCLES(S),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .rows(rows),
    .cols(cols),
    .col_idx(col_idx),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_press(evt_press),
    .key_state(key_state),
    .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] matrix(logic [3:0] c, logic [15:0] p);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (c[j] && p[i*4+j]) r[i] = 1'b1;
    return r;
  endfunction

  assign rows = matrix(cols, pressed);

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: slot position 0..S-1 settle, S sample, S+1..S+4 rows 0..3.
  bit        m_run;
  int        m_col;
  int        m_pos;
  bit [3:0]  m_samp;
  bit [15:0] m_ks;
  bit        m_ovf;
  bit [4:0]  m_q[$];

  task automatic model_reset();
    m_run = 0;
    m_col = 0;
    m_pos = 0;
    m_samp = '0;
    m_ks = '0;
    m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(bit en, bit rdy, bit clr, bit [15:0] pm);
    bit pop;
    bit drop;
    int r;
    int k;
    pop = (m_q.size() > 0) && rdy;
    drop = 0;
    if (m_run && m_pos > S) begin
      r = m_pos - S - 1;
      k = r * 4 + m_col;
      if (m_samp[r] != m_ks[k]) begin
        if (m_q.size() < D || pop) begin
          m_q.push_back({4'(k), m_samp[r]});
          m_ks[k] = m_samp[r];
        end else begin
          drop = 1;
        end
      end
    end
    if (pop) m_q.delete(0);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (m_run && m_pos == S)
      for (int i = 0; i < 4; i++) m_samp[i] = pm[i*4+m_col];
    if (!m_run) begin
      if (en) begin
        m_run = 1;
        m_col = 0;
        m_pos = 0;
      end
    end else if (m_pos == S + 4) begin
      m_pos = 0;
      if (en) m_col = (m_col + 1) % 4;
      else begin
        m_run = 0;
        m_col = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_all();
    chk("cols", 32'(cols), m_run ? 32'(1 << m_col) : 32'd0);
    chk("col_idx", 32'(col_idx), 32'(m_col));
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("head", 32'({evt_code, evt_press}), 32'(m_q[0]));
    chk("key_state", 32'(key_state), 32'(m_ks));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic run(int n, int p_rdy, int p_chg, int p_en, int p_clr);
    bit en;
    bit rdy;
    bit clr;
    repeat (n) begin
      check_all();
      if ($urandom_range(0, 99) < p_chg)
        pressed = pressed ^ (16'd1 << $urandom_range(0, 15));
      en  = $urandom_range(0, 99) < p_en;
      rdy = $urandom_range(0, 99) < p_rdy;
      clr = $urandom_range(0, 99) < p_clr;
      enable = en;
      evt_ready = rdy;
      clear_overflow = clr;
      model_step(en, rdy, clr, pressed);
      @(negedge clk);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_cols"}, 32'(cols), 32'd0);
    chk({tag, "_col_idx"}, 32'(col_idx), 32'd0);
    chk({tag, "_key_state"}, 32'(key_state), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_evt_code"}, 32'(evt_code), 32'd0);
    chk({tag, "_evt_press"}, 32'(evt_press), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    evt_ready = 1'b0;
    clear_overflow = 1'b0;
    pressed = '0;
    #1;
    check_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    run(600, 100, 3, 100, 0);
    run(400, 0, 6, 100, 0);
    run(600, 50, 4, 97, 2);
    run(300, 0, 6, 100, 0);

    #2 reset = 1'b1;
    #1 check_zero("async");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run(800, 70, 3, 98, 3);
    run(300, 30, 8, 90, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
